// File: rtl/vec_wb_sequencer.sv
// Write-back sequencer: takes one result vector group, merges it with the destination
// group under vl/vm/SEW (tail and mask undisturbed), writes it and waits for the acknowledge.
module vec_wb_sequencer #(
    parameter int VLEN       = 512,
    parameter int DATA_WIDTH = 8*VLEN,
    parameter int ADDR_WIDTH = 5,
    parameter int VL_WIDTH   = $clog2(DATA_WIDTH/8)+1,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    // A result transfers on the rising edge where res_valid and res_ready are both high;
    // the offer must stay stable until then, and res_ready is high only while idle.
    input  logic                  res_valid,
    output logic                  res_ready,
    input  logic [DATA_WIDTH-1:0] res_data,
    input  logic [ADDR_WIDTH-1:0] res_vd,
    input  logic [3:0]            res_lmul,
    input  logic [1:0]            res_sew,
    input  logic [VL_WIDTH-1:0]   res_vl,
    input  logic                  res_vm,
    input  logic                  res_mask_op,
    input  logic [DATA_WIDTH-1:0] dst_data,
    input  logic [VLEN-1:0]       v0_mask_data,
    input  logic                  data_written,
    input  logic                  wrong_addr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [3:0]            wb_lmul,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wr_en,
    output logic                  mask_wr_en,
    output logic                  wb_done,
    output logic                  wb_error,
    output logic [2:0]            fsm_state
);

    localparam int NBYTES = DATA_WIDTH/8;
    localparam int CNT_W  = $clog2(TIMEOUT+1);
    localparam int IDX_W  = $clog2(VLEN);

    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, WAIT} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] lat_data;
    logic [3:0]            lat_lmul;
    logic [1:0]            lat_sew;
    logic [VL_WIDTH-1:0]   lat_vl;
    logic                  lat_vm;

    logic                  req_ok;
    logic [DATA_WIDTH-1:0] merged;
    int                    group_bytes;
    int                    elem;

    assign fsm_state = state;

    // One-hot lmul equals its own numeric value, so alignment is a simple mask test.
    always_comb begin
        req_ok = 1'b1;
        if (!res_mask_op) begin
            if (!$onehot(res_lmul) || res_sew == 2'b11)
                req_ok = 1'b0;
            else if ((int'(res_vd) & (int'(res_lmul) - 1)) != 0)
                req_ok = 1'b0;
            else if (int'(res_vd) + int'(res_lmul) > (1 << ADDR_WIDTH))
                req_ok = 1'b0;
        end
    end

    // Per-byte merge: a byte belongs to element (byte >> sew); bytes past the group stay zero,
    // and elements past vl fall back to dst_data, which also realises min(vl, VLMAX).
    always_comb begin
        merged      = '0;
        elem        = 0;
        group_bytes = int'(lat_lmul) * (VLEN/8);
        for (int b = 0; b < NBYTES; b++) begin
            elem = b >> lat_sew;
            if (b < group_bytes) begin
                if (elem < int'(lat_vl) && (lat_vm || v0_mask_data[elem[IDX_W-1:0]]))
                    merged[b*8 +: 8] = lat_data[b*8 +: 8];
                else
                    merged[b*8 +: 8] = dst_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            res_ready  <= 1'b0;
            waddr      <= '0;
            wb_lmul    <= '0;
            wdata      <= '0;
            wr_en      <= 1'b0;
            mask_wr_en <= 1'b0;
            wb_done    <= 1'b0;
            wb_error   <= 1'b0;
            cnt        <= '0;
            lat_data   <= '0;
            lat_lmul   <= '0;
            lat_sew    <= '0;
            lat_vl     <= '0;
            lat_vm     <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            mask_wr_en <= 1'b0;
            wb_done    <= 1'b0;
            wb_error   <= 1'b0;
            case (state)
                IDLE: begin
                    res_ready <= 1'b1;
                    if (res_valid && res_ready) begin
                        lat_data <= res_data;
                        lat_lmul <= res_lmul;
                        lat_sew  <= res_sew;
                        lat_vl   <= res_vl;
                        lat_vm   <= res_vm;
                        if (!req_ok) begin
                            wb_error <= 1'b1;
                        end else if (res_mask_op) begin
                            waddr      <= '0;
                            wb_lmul    <= 4'b0001;
                            wdata      <= {{(DATA_WIDTH-VLEN){1'b0}}, res_data[VLEN-1:0]};
                            mask_wr_en <= 1'b1;
                            res_ready  <= 1'b0;
                            state      <= WRITE;
                        end else begin
                            waddr     <= res_vd;
                            wb_lmul   <= res_lmul;
                            res_ready <= 1'b0;
                            state     <= READ;
                        end
                    end
                end
                READ: state <= MERGE;
                MERGE: begin
                    wdata <= merged;
                    wr_en <= 1'b1;
                    state <= WRITE;
                end
                WRITE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (data_written) begin
                        wb_done   <= 1'b1;
                        res_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (wrong_addr || cnt == CNT_W'(TIMEOUT-1)) begin
                        wb_error  <= 1'b1;
                        res_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
